dmem_access_ctrl: RTL and testbench

Data-memory access controller for the MEM stage. It sequences each load and store from the EX/MEM register through a request/ready handshake with the data cache. While an access is outstanding it drives `cache_stall` to freeze the pipeline registers, including MEM_WB. It also detects word loads that hit the most recently completed store and drives `store_load_hazard` / `store_data_fwd` into MEM_WB, so those loads complete with no cache round-trip.

---
 rtl/dmem_access_ctrl_if.sv | 20 ++
 rtl/dmem_access_ctrl.sv | 105 ++++++++++
 tb/tb_dmem_access_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Request/ready bus between the MEM-stage access controller (master) and the data cache (slave).
interface dmem_access_ctrl_if;
  logic        cache_req;
  logic        cache_we;
  logic [31:0] cache_addr;
  logic [1:0]  cache_size;
  logic [31:0] cache_wdata;
  logic        cache_ready;
  logic [31:0] cache_rdata;

  modport master (
    output cache_req, cache_we, cache_addr, cache_size, cache_wdata,
    input  cache_ready, cache_rdata
  );

  modport slave (
    input  cache_req, cache_we, cache_addr, cache_size, cache_wdata,
    output cache_ready, cache_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: sequences loads/stores through the cache handshake,
// stalls the pipeline while an access is outstanding, and forwards word loads from the last word store.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_rd_en,
  input  logic                      mem_wr_en,
  input  logic [31:0]               mem_addr,
  input  logic [1:0]                mem_size,
  input  logic [31:0]               mem_wdata,
  dmem_access_ctrl_if.master        cbus,
  output logic                      cache_stall,
  output logic [31:0]               mem_data,
  output logic                      store_load_hazard,
  output logic [31:0]               store_data_fwd,
  output logic                      bus_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sb_valid;
  logic [31:2]   sb_addr;
  logic [31:0]   sb_data;

  logic access;
  logic fwd_hit;
  logic ready_hit;
  logic timeout_hit;

  assign access      = mem_rd_en | mem_wr_en;
  assign fwd_hit     = (state == IDLE) && mem_rd_en && (mem_size == SIZE_WORD) &&
                       sb_valid && (mem_addr[31:2] == sb_addr);
  assign ready_hit   = (state == WAIT) && cbus.cache_ready;
  assign timeout_hit = (state == WAIT) && !cbus.cache_ready && (cnt == CNT_LAST);

  // The pipeline is released in the ready cycle and in the abort cycle, so it advances at that edge.
  assign cache_stall       = (state == IDLE) ? (access && !fwd_hit) : !(cbus.cache_ready || timeout_hit);
  assign mem_data          = ready_hit ? cbus.cache_rdata : 32'h0;
  assign store_load_hazard = fwd_hit;
  assign store_data_fwd    = sb_data;

  // NOTE: all state below is updated with non-blocking assignments so every register samples
  // pre-edge values; blocking here would let later statements see half-updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cbus.cache_req   <= 1'b0;
      cbus.cache_we    <= 1'b0;
      cbus.cache_addr  <= 32'h0;
      cbus.cache_size  <= 2'b00;
      cbus.cache_wdata <= 32'h0;
      cnt              <= '0;
      sb_valid         <= 1'b0;
      sb_addr          <= '0;
      sb_data          <= 32'h0;
      bus_err          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access && !fwd_hit) begin
            state            <= WAIT;
            cbus.cache_req   <= 1'b1;
            cbus.cache_we    <= mem_wr_en;
            cbus.cache_addr  <= mem_addr;
            cbus.cache_size  <= mem_size;
            cbus.cache_wdata <= mem_wdata;
            cnt              <= '0;
          end
        end
        WAIT: begin
          if (cbus.cache_ready) begin
            state          <= IDLE;
            cbus.cache_req <= 1'b0;
            if (cbus.cache_we) begin
              // Only whole-word stores are buffered; a partial store to that word makes it stale.
              if (cbus.cache_size == SIZE_WORD) begin
                sb_valid <= 1'b1;
                sb_addr  <= cbus.cache_addr[31:2];
                sb_data  <= cbus.cache_wdata;
              end else if (cbus.cache_addr[31:2] == sb_addr) begin
                sb_valid <= 1'b0;
              end
            end
          end else if (cnt == CNT_LAST) begin
            state          <= IDLE;
            cbus.cache_req <= 1'b0;
            bus_err        <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vector table, hand-written reset/idle
// sequences, and randomized accesses checked against a transaction-level store-buffer model.
module tb_dmem_access_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rd_en = 1'b0;
  logic        mem_wr_en = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [1:0]  mem_size = 2'b00;
  logic [31:0] mem_wdata = 32'h0;
  logic        cache_stall;
  logic [31:0] mem_data;
  logic        store_load_hazard;
  logic [31:0] store_data_fwd;
  logic        bus_err;

  dmem_access_ctrl_if cbus();

  dmem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_rd_en         (mem_rd_en),
    .mem_wr_en         (mem_wr_en),
    .mem_addr          (mem_addr),
    .mem_size          (mem_size),
    .mem_wdata         (mem_wdata),
    .cbus              (cbus.master),
    .cache_stall       (cache_stall),
    .mem_data          (mem_data),
    .store_load_hazard (store_load_hazard),
    .store_data_fwd    (store_data_fwd),
    .bus_err           (bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level model of the store buffer and the sticky error flag.
  bit          m_sb_valid = 1'b0;
  logic [31:0] m_sb_word  = 32'h0;
  logic [31:0] m_sb_data  = 32'h0;
  bit          m_err      = 1'b0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          k;        // cycles after WAIT entry at which the cache answers
    logic [31:0] rdata;
    bit          exp_fwd;
    logic [31:0] exp_data; // forwarded data or load result
    bit          exp_err;  // bus_err after the access
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_fwd(input bit wr, input logic [31:0] addr, input logic [1:0] size);
    return !wr && size == 2'b10 && m_sb_valid && (addr >> 2) == m_sb_word;
  endfunction

  function automatic void model_update(input vec_t v);
    if (v.exp_fwd) return;
    if (v.k > TMO) begin
      m_err = 1'b1;
    end else if (v.wr) begin
      if (v.size == 2'b10) begin
        m_sb_valid = 1'b1;
        m_sb_word  = v.addr >> 2;
        m_sb_data  = v.wdata;
      end else if (m_sb_valid && (v.addr >> 2) == m_sb_word) begin
        m_sb_valid = 1'b0;
      end
    end
  endfunction

  // Presents one access (inputs held while stalled), plays the cache, checks every cycle.
  task automatic do_access(input vec_t v, input string tag);
    int last;
    mem_rd_en = !v.wr;
    mem_wr_en = v.wr;
    mem_addr  = v.addr;
    mem_size  = v.size;
    mem_wdata = v.wdata;
    cbus.cache_ready = 1'b0;
    @(negedge clk);
    if (v.exp_fwd) begin
      check({tag, " fwd hazard"}, store_load_hazard, 1);
      check({tag, " fwd data"}, store_data_fwd, v.exp_data);
      check({tag, " fwd stall"}, cache_stall, 0);
      check({tag, " fwd req"}, cbus.cache_req, 0);
      next_cycle();
    end else begin
      check({tag, " issue stall"}, cache_stall, 1);
      check({tag, " issue hazard"}, store_load_hazard, 0);
      check({tag, " issue req"}, cbus.cache_req, 0);
      last = (v.k < TMO) ? v.k : TMO;
      next_cycle();
      for (int i = 1; i <= last; i++) begin
        cbus.cache_ready = (i == v.k);
        cbus.cache_rdata = (i == v.k) ? v.rdata : $urandom;
        @(negedge clk);
        check({tag, " wait req"}, cbus.cache_req, 1);
        check({tag, " wait we"}, cbus.cache_we, v.wr);
        check({tag, " wait addr"}, cbus.cache_addr, v.addr);
        check({tag, " wait size"}, cbus.cache_size, v.size);
        if (v.wr) check({tag, " wait wdata"}, cbus.cache_wdata, v.wdata);
        check({tag, " wait stall"}, cache_stall, (i < last) ? 1 : 0);
        if (i == last && (!v.wr || v.k > TMO)) check({tag, " result"}, mem_data, v.exp_data);
        if (i < last) check({tag, " wait mem_data"}, mem_data, 0);
        next_cycle();
      end
      cbus.cache_ready = 1'b0;
      check({tag, " req dropped"}, cbus.cache_req, 0);
    end
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    check({tag, " bus_err"}, bus_err, v.exp_err);
    model_update(v);
  endtask

  vec_t tbl[12];

  initial begin
    cbus.cache_ready = 1'b0;
    cbus.cache_rdata = 32'h0;

    //          wr  addr          size   wdata         k   rdata         fwd data          err
    tbl[0]  = '{0, 32'h0000_0100, 2'b10, 32'h0,        3,  32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0};
    tbl[1]  = '{1, 32'h0000_0200, 2'b10, 32'h1234_5678, 1, 32'h0,         0, 32'h0,         0};
    tbl[2]  = '{0, 32'h0000_0200, 2'b10, 32'h0,        1,  32'h0,         1, 32'h1234_5678, 0};
    tbl[3]  = '{1, 32'h0000_0201, 2'b00, 32'h0000_AB00, 2, 32'h0,         0, 32'h0,         0};
    tbl[4]  = '{0, 32'h0000_0200, 2'b10, 32'h0,        1,  32'h1234_AB78, 0, 32'h1234_AB78, 0};
    tbl[5]  = '{1, 32'h0000_0300, 2'b10, 32'hDEAD_BEEF, 2, 32'h0,         0, 32'h0,         0};
    tbl[6]  = '{0, 32'h0000_0300, 2'b01, 32'h0,        1,  32'h0000_BEEF, 0, 32'h0000_BEEF, 0};
    tbl[7]  = '{0, 32'h0000_0304, 2'b10, 32'h0,        2,  32'h0000_0055, 0, 32'h0000_0055, 0};
    tbl[8]  = '{0, 32'h0000_0300, 2'b10, 32'h0,        1,  32'h0,         1, 32'hDEAD_BEEF, 0};
    tbl[9]  = '{0, 32'h0000_0400, 2'b10, 32'h0,        9,  32'h1111_1111, 0, 32'h0,         1};
    tbl[10] = '{0, 32'h0000_0300, 2'b10, 32'h0,        1,  32'h0,         1, 32'hDEAD_BEEF, 1};
    tbl[11] = '{0, 32'h0000_0500, 2'b10, 32'h0,        4,  32'h0000_0077, 0, 32'h0000_0077, 1};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst req", cbus.cache_req, 0);
    check("rst we", cbus.cache_we, 0);
    check("rst addr", cbus.cache_addr, 0);
    check("rst size", cbus.cache_size, 0);
    check("rst wdata", cbus.cache_wdata, 0);
    check("rst stall", cache_stall, 0);
    check("rst mem_data", mem_data, 0);
    check("rst hazard", store_load_hazard, 0);
    check("rst fwd data", store_data_fwd, 0);
    check("rst bus_err", bus_err, 0);
    next_cycle();

    for (int i = 0; i < 12; i++) do_access(tbl[i], $sformatf("vec%0d", i));

    // Ready pulse while idle: no output change, store buffer untouched.
    cbus.cache_ready = 1'b1;
    cbus.cache_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("idle ready stall", cache_stall, 0);
    check("idle ready mem_data", mem_data, 0);
    check("idle ready fwd data", store_data_fwd, 32'hDEAD_BEEF);
    next_cycle();
    cbus.cache_ready = 1'b0;
    check("idle ready req", cbus.cache_req, 0);
    do_access('{0, 32'h0000_0300, 2'b10, 32'h0, 1, 32'h0, 1, 32'hDEAD_BEEF, 1}, "post idle ready");

    // Randomized accesses against the model.
    for (int n = 0; n < 200; n++) begin
      vec_t v;
      v.wr    = $urandom_range(0, 1);
      v.size  = 2'($urandom_range(0, 2));
      v.addr  = 32'h100 + 32'($urandom_range(0, 3)) * 4;
      if (v.size == 2'b00) v.addr = v.addr + 32'($urandom_range(0, 3));
      if (v.size == 2'b01) v.addr = v.addr + 32'($urandom_range(0, 1)) * 2;
      v.wdata = $urandom;
      v.k     = (($urandom_range(0, 15)) == 0) ? TMO + 1 : int'($urandom_range(1, TMO));
      v.rdata = $urandom;
      v.exp_fwd  = model_fwd(v.wr, v.addr, v.size);
      v.exp_data = v.exp_fwd ? m_sb_data : ((v.k > TMO) ? 32'h0 : v.rdata);
      v.exp_err  = m_err || (!v.exp_fwd && v.k > TMO);
      do_access(v, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 3) == 0) begin
        cbus.cache_ready = $urandom_range(0, 1);
        cbus.cache_rdata = $urandom;
        @(negedge clk);
        check("rnd idle stall", cache_stall, 0);
        check("rnd idle hazard", store_load_hazard, 0);
        check("rnd idle mem_data", mem_data, 0);
        next_cycle();
        cbus.cache_ready = 1'b0;
      end
    end

    // Reset in the middle of WAIT: request drops at once, the late ready is ignored.
    do_access('{1, 32'h0000_0600, 2'b10, 32'hA5A5_5A5A, 1, 32'h0, 0, 32'h0, m_err}, "pre-rst store");
    mem_rd_en = 1'b1;
    mem_addr  = 32'h0000_0700;
    mem_size  = 2'b10;
    next_cycle();
    check("mid-wait req", cbus.cache_req, 1);
    #2;
    rst = 1'b1;
    mem_rd_en = 1'b0;
    #1;
    check("async rst req", cbus.cache_req, 0);
    check("async rst bus_err", bus_err, 0);
    check("async rst addr", cbus.cache_addr, 0);
    check("async rst fwd data", store_data_fwd, 0);
    check("async rst stall", cache_stall, 0);
    m_sb_valid = 1'b0;
    m_err      = 1'b0;
    next_cycle();
    rst = 1'b0;
    cbus.cache_ready = 1'b1;
    cbus.cache_rdata = 32'h7777_7777;
    @(negedge clk);
    check("late ready mem_data", mem_data, 0);
    check("late ready stall", cache_stall, 0);
    next_cycle();
    cbus.cache_ready = 1'b0;
    check("late ready req", cbus.cache_req, 0);
    do_access('{0, 32'h0000_0600, 2'b10, 32'h0, 2, 32'h0123_4567, 0, 32'h0123_4567, 0}, "post-rst load");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
